// File: rtl/apb_cmd_master24.sv
// APB Rev2 initiator: one valid/ready command in, one APB transfer out,
// one valid/ready response back, with pready waits and access timeout.
//
// Ports:
//   pclk24, n_p_reset24          clock, async active-low reset
//   cmd_valid24/ready24          command handshake
//   cmd_write24/addr24/wdata24   command fields
//   rsp_valid24/ready24          response handshake
//   rsp_rdata24, rsp_err24       read data (0 on write/error), timeout flag
//   psel24, penable24, pwrite24  APB control
//   paddr24, pwdata24, prdata24  APB address/data
//   pready24                     APB slave ready
module apb_cmd_master24 #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              pclk24,
    input  logic              n_p_reset24,
    input  logic              cmd_valid24,
    output logic              cmd_ready24,
    input  logic              cmd_write24,
    input  logic [ADDR_W-1:0] cmd_addr24,
    input  logic [31:0]       cmd_wdata24,
    output logic              rsp_valid24,
    input  logic              rsp_ready24,
    output logic [31:0]       rsp_rdata24,
    output logic              rsp_err24,
    output logic              psel24,
    output logic              penable24,
    output logic              pwrite24,
    output logic [ADDR_W-1:0] paddr24,
    output logic [31:0]       pwdata24,
    input  logic [31:0]       prdata24,
    input  logic              pready24
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rdy_q;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    // rdy_q keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge pclk24 or negedge n_p_reset24) begin
        if (!n_p_reset24) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_q    <= 1'b1;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid24 && cmd_ready24) begin
                    pwrite_d = cmd_write24;
                    paddr_d  = cmd_addr24;
                    pwdata_d = cmd_wdata24;
                    cnt_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // Completion has priority over a timeout in the same cycle.
                if (pready24) begin
                    rdata_d = pwrite_q ? 32'h0 : prdata24;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (TIMEOUT_CYC != 0 && cnt_q == TO_LIM) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready24) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded from the state register so reset clears them at once.
    assign cmd_ready24 = rdy_q && (state_q == S_IDLE);
    assign psel24      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable24   = (state_q == S_ACCESS);
    assign rsp_valid24 = (state_q == S_RESP);
    assign pwrite24    = pwrite_q;
    assign paddr24     = paddr_q;
    assign pwdata24    = pwdata_q;
    assign rsp_rdata24 = rdata_q;
    assign rsp_err24   = err_q;

endmodule

// File: tb/tb_apb_cmd_master24.sv
// Randomized scoreboard bench for apb_cmd_master24 with an APB
// slave model and a memory-level reference model.
module tb_apb_cmd_master24;

    localparam int TO = 16;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready;

    apb_cmd_master24 #(.ADDR_W(6), .TIMEOUT_CYC(TO)) dut (
        .pclk24(clk), .n_p_reset24(rst_n),
        .cmd_valid24(cmd_valid), .cmd_ready24(cmd_ready),
        .cmd_write24(cmd_write), .cmd_addr24(cmd_addr),
        .cmd_wdata24(cmd_wdata),
        .rsp_valid24(rsp_valid), .rsp_ready24(rsp_ready),
        .rsp_rdata24(rsp_rdata), .rsp_err24(rsp_err),
        .psel24(psel), .penable24(penable), .pwrite24(pwrite),
        .paddr24(paddr), .pwdata24(pwdata),
        .prdata24(prdata), .pready24(pready)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          len;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   wait_q[$];
    int   stall_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] ref_mem [64] = '{default: 32'h0};
    logic [31:0] smem    [64] = '{default: 32'h0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // APB slave: pready rises after a per-transfer number of wait cycles.
    int acc_cnt   = 0;
    int cur_waits = 0;
    assign pready = (acc_cnt >= cur_waits);
    assign prdata = smem[paddr];

    always @(posedge clk) begin
        if (psel && !penable && wait_q.size() > 0)
            cur_waits <= wait_q.pop_front();
        if (psel && penable) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
        if (psel && penable && pready && pwrite)
            smem[paddr] <= pwdata;
    end

    // Response consumer with per-response stall.
    int stall_left = 0;
    bit in_rsp = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_rsp = 0;
            rsp_ready = 1'b1;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                in_rsp = 1;
                stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
            end
            if (stall_left > 0) begin
                rsp_ready = 1'b0;
                stall_left--;
            end else begin
                rsp_ready = 1'b1;
            end
        end else begin
            in_rsp = 0;
            rsp_ready = 1'b1;
        end
    end

    // Monitor / scoreboard.
    int          pen_cnt = 0, last_len = 0, first_cyc = 0;
    bit          held = 0, chk_idle = 0, prev_v = 0;
    logic [31:0] hd;
    logic        he;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            pen_cnt = 0; held = 0; chk_idle = 0; prev_v = 0;
        end else begin
            if (penable && !psel) chk("pen_wo_sel", 1, 0);
            if (psel && penable) pen_cnt++;
            else if (pen_cnt > 0) begin
                last_len = pen_cnt;
                pen_cnt = 0;
            end
            if (chk_idle) begin
                chk("idle_after_acc", cmd_ready, 1);
                chk_idle = 0;
            end
            if (rsp_valid && !prev_v) first_cyc = cyc;
            if (rsp_valid && held) begin
                chk("stable_rdata", rsp_rdata, hd);
                chk("stable_err", rsp_err, he);
            end
            if (rsp_valid) begin
                chk("rdy_in_resp", cmd_ready, 0);
                chk("psel_in_resp", psel, 0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", rsp_rdata, e.data);
                    chk("err", rsp_err, e.err);
                    chk("access_len", last_len, e.len);
                    chk("latency", first_cyc - e.acc, 1 + e.len);
                end
                held = 0;
                chk_idle = 1;
            end else if (rsp_valid) begin
                held = 1;
                hd = rsp_rdata;
                he = rsp_err;
            end
            prev_v = rsp_valid;
        end
    end

    // Reference model: memory semantics plus timeout rule.
    function automatic exp_t model(input logic w, input logic [5:0] a,
                                   input logic [31:0] d, input int waits);
        exp_t r;
        r.err  = (TO != 0) && (waits > TO);
        r.len  = r.err ? TO + 1 : waits + 1;
        r.data = (w || r.err) ? 32'h0 : ref_mem[a];
        r.acc  = 0;
        if (w && !r.err) ref_mem[a] = d;
        return r;
    endfunction

    task automatic issue(input logic w, input logic [5:0] a,
                         input logic [31:0] d, input int waits,
                         input int stall);
        exp_t r;
        bit got = 0;
        @(posedge clk); #1;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        r = model(w, a, d, waits);
        r.acc = cyc + 1;
        exp_q.push_back(r);
        wait_q.push_back(waits);
        stall_q.push_back(stall);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 0);
    endtask

    int prev_acc, r, wt;
    bit got;
    exp_t rr;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rel_cmd_ready0", cmd_ready, 0);
        @(negedge clk);
        chk("rel_cmd_ready1", cmd_ready, 1);

        issue(1, 6'h04, 32'h0000_A5A5, 0, 0);
        issue(0, 6'h04, 32'h0, 0, 0);
        issue(1, 6'h08, 32'h1234_5678, 0, 0);
        issue(0, 6'h08, 32'h0, 3, 0);
        issue(0, 6'h08, 32'h0, 100, 0);
        issue(0, 6'h04, 32'h0, 0, 0);
        issue(0, 6'h08, 32'h0, TO, 0);
        issue(1, 6'h10, 32'hDEAD_BEEF, 0, 0);
        issue(0, 6'h10, 32'h0, 0, 5);
        drain();

        // Back-to-back with cmd_valid held high.
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 8; k++) begin
            cmd_write = k[0];
            cmd_addr  = 6'(k + 32);
            cmd_wdata = $urandom;
            got = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                chk("b2b_accept", 0, 1);
                break;
            end
            rr = model(cmd_write, cmd_addr, cmd_wdata, 0);
            rr.acc = cyc + 1;
            if (k > 0) chk("b2b_spacing", rr.acc - prev_acc, 4);
            prev_acc = rr.acc;
            exp_q.push_back(rr);
            wait_q.push_back(0);
            stall_q.push_back(0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        drain();

        // Reset during ACCESS.
        issue(0, 6'h04, 32'h0, 6, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (penable) break;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        exp_q.delete(); wait_q.delete(); stall_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("mid_rel_rdy0", cmd_ready, 0);
        @(negedge clk);
        chk("mid_rel_rdy1", cmd_ready, 1);
        issue(0, 6'h04, 32'h0, 0, 0);
        drain();

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       wt = 0;
            else if (r == 5) wt = 1;
            else if (r == 6) wt = 3;
            else if (r == 7) wt = TO;
            else if (r == 8) wt = TO + 1;
            else             wt = $urandom_range(2, 8);
            issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
                  $urandom, wt, $urandom_range(0, 3));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master24.md
Name: apb_cmd_master24

Overview:
APB Rev2 initiator (bridge side) that turns a simple valid/ready command interface into single APB transfers towards apb_subsystem24 peripherals such as the GPIO responder. It drives psel/penable/pwrite/paddr/pwdata and captures prdata. It returns one response per command on a valid/ready response port. It supports an optional pready wait input and a programmable access timeout, so a hung slave cannot stall the subsystem.

Parameters:
ADDR_W, 6, paddr24/cmd_addr24 width in bits.
TIMEOUT_CYC, 16, max ACCESS cycles with pready24 low before forced termination; 0 = no timeout; legal range 0..255.

Ports:
pclk24  in  1  peripheral clock; all state changes on its rising edge
n_p_reset24  in  1  asynchronous active-low reset
cmd_valid24  in  1  command present
cmd_ready24  out  1  block can accept a command
cmd_write24  in  1  1 = write, 0 = read
cmd_addr24  in  ADDR_W  transfer address
cmd_wdata24  in  32  write data
rsp_valid24  out  1  response present
rsp_ready24  in  1  consumer accepts the response
rsp_rdata24  out  32  read data; 0 for writes and for errors
rsp_err24  out  1  1 = transfer terminated by timeout
psel24  out  1  APB select
penable24  out  1  APB enable
pwrite24  out  1  APB write strobe
paddr24  out  ADDR_W  APB address
pwdata24  out  32  APB write data
prdata24  in  32  APB read data
pready24  in  1  slave ready; tie to 1 for Rev2 slaves without wait states

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE; wait counter = 0.
  - psel24, penable24, pwrite24, rsp_valid24, rsp_err24 = 0.
  - paddr24, pwdata24, rsp_rdata24 = 0.
  - cmd_ready24 = 1 one cycle after reset deasserts; it is 0 while reset is asserted.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready24 = 1.
  - On cmd_valid24 & cmd_ready24, register cmd_write24/cmd_addr24/cmd_wdata24 into pwrite24/paddr24/pwdata24, then go to SETUP.
- SETUP:
  - psel24 = 1, penable24 = 0, cmd_ready24 = 0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - psel24 = 1, penable24 = 1.
  - pready24 = 1 at the clock edge: transfer completes. rsp_rdata24 <= pwrite24 ? 0 : prdata24; rsp_err24 <= 0; go to RESP.
  - pready24 = 0: increment the wait counter. If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC, go to RESP with rsp_err24 = 1 and rsp_rdata24 = 0.
  - The wait counter clears on entry to SETUP.
- RESP:
  - psel24 = penable24 = 0; rsp_valid24 = 1.
  - rsp_rdata24 and rsp_err24 stay stable until rsp_ready24 is seen high; then go to IDLE.
  - rsp_valid24 and rsp_err24 drop the cycle after acceptance.
- Latency with zero wait states: command accepted at edge T.
  - SETUP during cycle T+1.
  - ACCESS during T+2.
  - rsp_valid24 high during T+3.
  - With rsp_ready24 tied high, the next command can be accepted at edge T+4 (4 cycles/transfer).
- paddr24, pwrite24 and pwdata24 hold their values from SETUP through the end of ACCESS. They keep the last value in IDLE and RESP; they do not return to 0.
- Only one transfer is outstanding at a time. cmd_valid24 asserted outside IDLE is ignored, not queued.
- If pready24 rises in the same cycle the counter would hit TIMEOUT_CYC, completion wins: rsp_err24 = 0 and the data is captured.
- Timeout count: with TIMEOUT_CYC = N, ACCESS lasts at most N+1 cycles. The counter is 8 bits and never wraps, because termination happens at N ≤ 255.
- If reset asserts mid-transfer, psel24 and penable24 drop immediately (asynchronously). No response is produced for the aborted command.
- Whenever psel24 = 0, penable24 is never 1.

Test Plan:
- Write, then read-back: cmd write addr 0x04 data 0x0000_A5A5 with pready24 = 1.
  - Required: psel24 = 1 at T+1, penable24 = 1 at T+2, rsp_valid24 at T+3 with rsp_rdata24 = 0 and rsp_err24 = 0.
  - Then read addr 0x04 with the model returning 0xA5A5: rsp_rdata24 = 0x0000_A5A5.
- Wait states: pready24 held low 3 cycles in ACCESS on a read with prdata24 = 0x1234_5678.
  - Required: penable24 high 4 cycles, rsp_rdata24 = 0x1234_5678, rsp_err24 = 0, no timeout.
- Timeout: TIMEOUT_CYC = 16, pready24 held 0.
  - Required: ACCESS lasts 17 cycles, then psel24 = 0, rsp_valid24 = 1, rsp_err24 = 1, rsp_rdata24 = 0.
  - The next command completes normally with rsp_err24 = 0.
- Response back-pressure: rsp_ready24 held low 5 cycles after a read returning 0xDEAD_BEEF.
  - Required: rsp_valid24 and rsp_rdata24 stable for all 5 cycles, cmd_ready24 = 0 throughout, IDLE entered the cycle after acceptance.
- Back-to-back commands: 8 commands with cmd_valid24 always high and rsp_ready24 always high.
  - Required: exactly 8 responses, one transfer every 4 cycles, psel24 low for ≥1 cycle between transfers.
- Reset mid-transfer: assert n_p_reset24 during ACCESS.
  - Required: psel24, penable24 and rsp_valid24 = 0 immediately.
  - After release, cmd_ready24 = 1 and the first new command runs normally.
